ccd_frame_capture: RTL and testbench

Front-end capture stage between the sensor parallel port and the Bayer-to-RGB decimating demosaic. It registers raw 10-bit sensor data with FVAL/LVAL. It gates whole frames under start/stop control and emits pixel data with a data-valid strobe, X/Y coordinates and a completed-frame count. Its oDATA/oDVAL/oX_Cont/oY_Cont feed the demosaic's iDATA/iDVAL/iX_Cont/iY_Cont directly.

---
 rtl/ccd_frame_capture.sv | 146 ++++++++++++++
 tb/tb_ccd_frame_capture.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ccd_frame_capture.sv
// rtl/ccd_frame_capture.sv - sensor front-end: frame gating, pixel strobe, X/Y coordinates, frame count
// Optional build macro: CCD_TEST_PATTERN_EN (iTEST=1 replaces pixel data with X^Y)
module ccd_frame_capture #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 1024,
  parameter int FRAME_W  = 32
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [9:0]         iDATA,
  input  logic               iFVAL,
  input  logic               iLVAL,
  input  logic               iSTART,
  input  logic               iEND,
  input  logic               iTEST,
  output logic [9:0]         oDATA,
  output logic               oDVAL,
  output logic [10:0]        oX_Cont,
  output logic [10:0]        oY_Cont,
  output logic [FRAME_W-1:0] oFrame_Cont,
  output logic               oBUSY
);

  localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);
  localparam logic [10:0] Y_LAST = 11'(V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, STOP_PEND} state_t;

  state_t      state, state_nxt;
  logic [9:0]  r_data;
  logic        r_fval, r_lval, r_fval_d;
  logic        rise, fall, cap, frame_done;
  logic [10:0] xn, yn;
  logic [9:0]  pix;

  assign rise = r_fval & ~r_fval_d;
  assign fall = ~r_fval & r_fval_d;

  // A pixel is taken while capturing, or on the very cycle the frame starts in ARMED
  assign cap = ((state == CAPTURE) || (state == STOP_PEND) || ((state == ARMED) && rise))
               && r_fval && r_lval;

`ifdef CCD_TEST_PATTERN_EN
  assign pix = iTEST ? (xn[9:0] ^ yn[9:0]) : r_data;
`else
  logic unused_test;
  assign unused_test = iTEST;
  assign pix = r_data;
`endif

  // Stage 1: register the sensor port and keep a delayed FVAL for edge detection
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_data   <= '0;
      r_fval   <= 1'b0;
      r_lval   <= 1'b0;
      r_fval_d <= 1'b0;
    end else begin
      r_data   <= iDATA;
      r_fval   <= iFVAL;
      r_lval   <= iLVAL;
      r_fval_d <= r_fval;
    end
  end

  // State register, busy flag (from next state) and completed-frame counter
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state       <= IDLE;
      oBUSY       <= 1'b0;
      oFrame_Cont <= '0;
    end else begin
      state <= state_nxt;
      oBUSY <= (state_nxt == CAPTURE) || (state_nxt == STOP_PEND);
      if (frame_done) oFrame_Cont <= oFrame_Cont + FRAME_W'(1);
    end
  end

  // Next-state logic; stop wins over start, and a started frame always runs to its end
  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (iSTART && !iEND) state_nxt = ARMED;
      end
      ARMED: begin
        if (iEND)      state_nxt = IDLE;
        else if (rise) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (fall) begin
          frame_done = 1'b1;
          state_nxt  = iEND ? IDLE : ARMED;
        end else if (iEND) begin
          state_nxt = STOP_PEND;
        end
      end
      STOP_PEND: begin
        if (fall) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end else if (iSTART && !iEND) begin
          state_nxt = CAPTURE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage 2: output pixel, strobe and the coordinates of that pixel
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oDVAL   <= 1'b0;
      oDATA   <= '0;
      oX_Cont <= '0;
      oY_Cont <= '0;
    end else begin
      oDVAL <= cap;
      if (cap) begin
        oDATA   <= pix;
        oX_Cont <= xn;
        oY_Cont <= yn;
      end
    end
  end

  // Line-length driven position counters; only a frame end resynchronises them
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      xn <= '0;
      yn <= '0;
    end else if (fall) begin
      xn <= '0;
      yn <= '0;
    end else if (cap) begin
      if (xn == X_LAST) begin
        xn <= '0;
        yn <= (yn == Y_LAST) ? 11'd0 : yn + 11'd1;
      end else begin
        xn <= xn + 11'd1;
      end
    end
  end

endmodule

// File: tb/tb_ccd_frame_capture.sv
// tb/tb_ccd_frame_capture.sv - self-checking bench for ccd_frame_capture
module tb_ccd_frame_capture;
  localparam int H  = 4;
  localparam int V  = 3;
  localparam int FW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [9:0]    din = '0;
  logic          fval = 1'b0, lval = 1'b0, start = 1'b0, stop = 1'b0, test = 1'b0;
  logic [9:0]    odata;
  logic          odval;
  logic [10:0]   ox, oy;
  logic [FW-1:0] ofc;
  logic          obusy;

  ccd_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FRAME_W(FW)) dut (
    .iCLK(clk), .iRST(rst_n), .iDATA(din), .iFVAL(fval), .iLVAL(lval),
    .iSTART(start), .iEND(stop), .iTEST(test),
    .oDATA(odata), .oDVAL(odval), .oX_Cont(ox), .oY_Cont(oy),
    .oFrame_Cont(ofc), .oBUSY(obusy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed pixel stream
  int got_d[$], got_x[$], got_y[$], got_c[$];
  always @(negedge clk) begin
    if (odval === 1'b1) begin
      got_d.push_back(int'(odata));
      got_x.push_back(int'(ox));
      got_y.push_back(int'(oy));
      got_c.push_back(cyc);
    end
  end

  // Expected pixel stream from the reference model
  int exp_d[$], exp_x[$], exp_y[$], exp_c[$];

  int   n_pass = 0, n_total = 0;
  int   exp_fc = 0;
  logic busy_mid;
  logic [63:0] snap;
  int   n_at_rst;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Sensor frame of V lines x H pixels with random data and blanking; the model
  // lists every pixel a captured frame must produce, in raster order, 2 cycles late
  task automatic drive_frame(input int start_at, input int end_at, input int rst_at,
                             input int probe_at, input bit cap_exp, input bit tsel);
    bit         qf[$], ql[$];
    logic [9:0] qd[$];
    int         fp, k, ex;
    logic [9:0] pat;
    fp = $urandom_range(0, 1);
    k  = 0;
    for (int i = 0; i < fp; i++) begin qf.push_back(1); ql.push_back(0); qd.push_back('0); end
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        qf.push_back(1); ql.push_back(1); qd.push_back(10'($urandom_range(0, 1023)));
      end
      if (y < V - 1) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
          qf.push_back(1); ql.push_back(0); qd.push_back('0);
        end
      end
    end
    for (int b = 0; b < int'($urandom_range(3, 5)); b++) begin
      qf.push_back(0); ql.push_back(0); qd.push_back('0);
    end
    foreach (qf[i]) begin
      @(negedge clk);
      if (i == probe_at) busy_mid = obusy;
      test  = tsel;
      fval  = qf[i];
      lval  = ql[i];
      din   = qd[i];
      start = (i == start_at);
      stop  = (i == end_at);
      if (cap_exp && ql[i]) begin
        ex  = (k % H) ^ ((k / H) % V);
        pat = 10'(ex);
`ifdef CCD_TEST_PATTERN_EN
        exp_d.push_back(tsel ? int'(pat) : int'(qd[i]));
`else
        exp_d.push_back(tsel ? int'(qd[i]) : int'(qd[i] | (pat & 10'd0)));
`endif
        exp_x.push_back(k % H);
        exp_y.push_back((k / H) % V);
        exp_c.push_back(cyc + 2);
        k++;
      end
      if (i == rst_at) begin
        #2 rst_n = 1'b0;
        #1 snap = {odval, odata, ox, oy, ofc, obusy};
        n_at_rst = got_d.size();
      end else begin
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0; stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse(input logic s, input logic e);
    @(negedge clk);
    start = s; stop = e;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    chk({tag, " count"}, got_d.size(), exp_d.size());
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      chk($sformatf("%s px%0d data", tag, i), got_d[i], exp_d[i]);
      chk($sformatf("%s px%0d x", tag, i), got_x[i], exp_x[i]);
      chk($sformatf("%s px%0d y", tag, i), got_y[i], exp_y[i]);
      chk($sformatf("%s px%0d latency", tag, i), got_c[i], exp_c[i]);
    end
    got_d.delete(); got_x.delete(); got_y.delete(); got_c.delete();
    exp_d.delete(); exp_x.delete(); exp_y.delete(); exp_c.delete();
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst dval", odval, 0);
    chk("rst data", odata, 0);
    chk("rst x", ox, 0);
    chk("rst y", oy, 0);
    chk("rst frames", ofc, 0);
    chk("rst busy", obusy, 0);
    rst_n = 1'b1;

    // Sensor running without a start request: nothing is captured
    drive_frame(-1, -1, -1, -1, 0, 1'($urandom_range(0, 1)));
    check_frame("idle");
    chk("idle frames", ofc, 0);
    chk("idle busy", obusy, 0);

    // Start, then one frame captured; busy while capturing, ARMED afterwards
    pulse(1'b1, 1'b0);
    drive_frame(-1, -1, -1, H + 3, 1, 1'b0);
    exp_fc++;
    chk("cap1 busy mid", busy_mid, 1);
    check_frame("cap1");
    chk("cap1 frames", ofc, exp_fc);
    chk("cap1 busy after", obusy, 0);

    // Continuous capture, including a frame with the test-pattern select raised
    drive_frame(-1, -1, -1, -1, 1, 1'b1);
    exp_fc++;
    check_frame("cont tsel");
    chk("cont tsel frames", ofc, exp_fc);
    drive_frame(-1, -1, -1, -1, 1, 1'($urandom_range(0, 1)));
    exp_fc++;
    check_frame("cont");
    chk("cont frames", ofc, exp_fc);

    // Stop request during line 1: frame completes, then capture stops
    drive_frame(-1, H + 4, -1, H + 6, 1, 1'b0);
    exp_fc++;
    chk("stop busy pend", busy_mid, 1);
    check_frame("stop");
    chk("stop frames", ofc, exp_fc);
    chk("stop busy after", obusy, 0);
    drive_frame(-1, -1, -1, -1, 0, 1'b0);
    check_frame("after stop");
    chk("after stop frames", ofc, exp_fc);

    // Arming mid-frame skips that frame; the next one is captured
    drive_frame(5, -1, -1, -1, 0, 1'b0);
    check_frame("midarm skip");
    chk("midarm skip frames", ofc, exp_fc);
    drive_frame(-1, -1, -1, -1, 1, 1'b0);
    exp_fc++;
    check_frame("midarm next");
    chk("midarm next frames", ofc, exp_fc);

    // Start and stop together while ARMED: stop wins
    pulse(1'b1, 1'b1);
    chk("simul busy", obusy, 0);
    drive_frame(-1, -1, -1, -1, 0, 1'b0);
    check_frame("simul");
    chk("simul frames", ofc, exp_fc);

    // Asynchronous reset in the middle of a captured line
    pulse(1'b1, 1'b0);
    drive_frame(-1, -1, 2, -1, 0, 1'b0);
    chk("rst mid outputs", snap, 0);
    chk("rst mid no more px", got_d.size(), n_at_rst);
    got_d.delete(); got_x.delete(); got_y.delete(); got_c.delete();
    exp_fc = 0;
    chk("rst mid frames", ofc, exp_fc);
    drive_frame(-1, -1, -1, -1, 0, 1'b0);
    check_frame("post rst idle");
    drive_frame(5, -1, -1, -1, 0, 1'b0);
    check_frame("post rst midarm");
    drive_frame(-1, -1, -1, -1, 1, 1'($urandom_range(0, 1)));
    exp_fc++;
    check_frame("post rst cap");
    chk("post rst frames", ofc, exp_fc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
